// File: rtl/pblaze_io_hub.sv
// pblaze_io_hub: KCPSM6 port-bus hub providing output registers with write pulses,
// a registered input mux with read pulses, and edge-detected interrupts with
// pending/mask registers and an interrupt/interrupt_ack handshake.
// Optional macro PBLAZE_IO_READBACK_EN: reads at OUT_BASE+i return output channel i.
module pblaze_io_hub #(
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_IRQ    = 4,
  parameter logic [7:0]  OUT_BASE = 8'h00,
  parameter logic [7:0]  IN_BASE  = 8'h10,
  parameter logic [7:0]  IRQ_BASE = 8'hF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 write_strobe,
  input  logic                 k_write_strobe,
  input  logic                 read_strobe,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  output logic [8*N_OUT-1:0]   out_data,
  output logic [N_OUT-1:0]     out_wr_pulse,
  input  logic [8*N_IN-1:0]    in_data,
  output logic [N_IN-1:0]      in_rd_pulse,
  input  logic [N_IRQ-1:0]     irq_src
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} irq_state_e;

  irq_state_e       irq_state_q;
  logic [N_IRQ-1:0] irq_src_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;

  logic [7:0]       out_off;
  logic [7:0]       in_off;
  logic [N_OUT-1:0] out_hit;
  logic [N_IN-1:0]  in_hit;
  logic             pend_wr;
  logic             mask_wr;
  logic [N_IRQ-1:0] src_edge;
  logic [N_IRQ-1:0] pend_clr;
  logic [N_IRQ-1:0] pending_d;
  logic             irq_active;
  logic [7:0]       rd_data;

  // Offsets wrap modulo 256, so addresses below a base land far outside the channel range.
  assign out_off    = port_id - OUT_BASE;
  assign in_off     = port_id - IN_BASE;
  assign pend_wr    = write_strobe && (port_id == IRQ_BASE);
  assign mask_wr    = write_strobe && (port_id == IRQ_BASE + 8'd1);
  assign src_edge   = irq_src & ~irq_src_q;
  assign pend_clr   = pend_wr ? out_port[N_IRQ-1:0] : '0;
  // Set has priority over write-1-to-clear on the same bit.
  assign pending_d  = (pending_q & ~pend_clr) | src_edge;
  assign irq_active = |(pending_q & mask_q);

  // Address decode for output writes (full OUTPUT decode, low-nibble OUTPUTK decode) and inputs.
  always_comb begin
    out_hit = '0;
    in_hit  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_hit[i] = (write_strobe && (out_off == 8'(i))) ||
                   (k_write_strobe && (port_id[3:0] == 4'(i)));
    end
    for (int i = 0; i < N_IN; i++) begin
      in_hit[i] = (in_off == 8'(i));
    end
  end

  // Read mux; later assignments take priority, so the IN range wins any overlap.
  always_comb begin
    rd_data = 8'h00;
`ifdef PBLAZE_IO_READBACK_EN
    for (int i = 0; i < N_OUT; i++) begin
      if (out_off == 8'(i)) rd_data = out_data[8*i +: 8];
    end
`endif
    if (port_id == IRQ_BASE) begin
      rd_data = 8'(pending_q);
    end else if (port_id == IRQ_BASE + 8'd1) begin
      rd_data = 8'(mask_q);
    end
    for (int i = 0; i < N_IN; i++) begin
      if (in_hit[i]) rd_data = in_data[8*i +: 8];
    end
  end

  // Output registers, write/read pulses and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data     <= '0;
      out_wr_pulse <= '0;
      in_rd_pulse  <= '0;
      in_port      <= 8'h00;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (out_hit[i]) out_data[8*i +: 8] <= out_port;
      end
      out_wr_pulse <= out_hit;
      in_rd_pulse  <= read_strobe ? in_hit : '0;
      in_port      <= rd_data;
    end
  end

  // Interrupt edge detect, pending and mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Capture current sources so a level already high at reset is not seen as an edge.
      irq_src_q <= irq_src;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      irq_src_q <= irq_src;
      pending_q <= pending_d;
      if (mask_wr) mask_q <= out_port[N_IRQ-1:0];
    end
  end

  // Interrupt handshake FSM with registered interrupt output.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_state_q <= StIdle;
      interrupt   <= 1'b0;
    end else begin
      unique case (irq_state_q)
        StIdle: begin
          if (irq_active) begin
            irq_state_q <= StAssert;
            interrupt   <= 1'b1;
          end
        end
        StAssert: begin
          // Held until acknowledged even if the request has since been masked off.
          if (interrupt_ack) begin
            irq_state_q <= StService;
            interrupt   <= 1'b0;
          end
        end
        StService: begin
          interrupt <= 1'b0;
          if (pend_wr) irq_state_q <= StIdle;
        end
        default: begin
          irq_state_q <= StIdle;
          interrupt   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pblaze_io_hub.md
Name: pblaze_io_hub

Overview:
- Parametrised I/O and interrupt hub that sits on the KCPSM6 port bus, beside the processor and program ROM wrapper.
- Replaces ad-hoc per-design port decode with three services:
  - N_OUT output registers, each with a write pulse.
  - N_IN input channels multiplexed onto in_port through a registered mux.
  - N_IRQ edge-detected interrupt sources with pending and mask registers, plus an interrupt/interrupt_ack handshake to KCPSM6.

Parameters:
- N_OUT, 4, number of 8-bit output registers (1..16).
- N_IN, 4, number of 8-bit input channels (1..16).
- N_IRQ, 4, number of interrupt sources (1..8).
- OUT_BASE, 8'h00, first output port_id; must be a multiple of 16.
- IN_BASE, 8'h10, first input port_id; its range must not overlap the IRQ range.
- IRQ_BASE, 8'hF0, IRQ register block: +0 = PENDING, +1 = MASK.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- port_id  in  8  KCPSM6 port address
- out_port  in  8  KCPSM6 write data
- write_strobe  in  1  OUTPUT strobe
- k_write_strobe  in  1  OUTPUTK strobe
- read_strobe  in  1  INPUT strobe
- in_port  out  8  read data to KCPSM6
- interrupt  out  1  interrupt request to KCPSM6
- interrupt_ack  in  1  KCPSM6 acknowledge
- out_data  out  8*N_OUT  output registers; channel i at bits [8i+7:8i]
- out_wr_pulse  out  N_OUT  one-cycle pulse per written channel
- in_data  in  8*N_IN  input channel data
- in_rd_pulse  out  N_IN  one-cycle pulse per read channel
- irq_src  in  N_IRQ  interrupt sources, synchronous to clk

Behaviour:
- Reset: one clock, synchronous, active-high. Every register clears on the reset edge: out_data=0, out_wr_pulse=0, in_rd_pulse=0, in_port=0x00, interrupt=0, PENDING=0, MASK=0, FSM=IDLE. The edge-detect register loads the current irq_src, so a source already high at reset does not set PENDING.
- Write decode:
  - write_strobe decodes the full 8-bit port_id.
  - k_write_strobe decodes port_id[3:0] only, and only against the output range (index = port_id[3:0]).
  - A hit on channel i with i<N_OUT loads out_port into channel i on the same edge; out_wr_pulse[i]=1 for the following cycle only.
  - Writes with no hit are ignored.
- Read path:
  - in_port is registered every cycle, independent of read_strobe: in_port <= mux(port_id), 1-cycle latency.
  - KCPSM6 holds port_id for 2 cycles, so data is valid when sampled.
  - Mux results: IN_BASE+i returns in_data channel i; IRQ_BASE+0 returns PENDING (zero-extended); IRQ_BASE+1 returns MASK; anything else returns 0x00.
  - in_rd_pulse[i] is 1 for the cycle after the read_strobe cycle, for the decoded input channel only.
- IRQ pending:
  - edge[j] = irq_src[j] & ~irq_src_d[j].
  - PENDING[j] is set by edge[j].
  - Writing 1 to bit j at IRQ_BASE+0 clears PENDING[j] (write-1-to-clear); writing 0 has no effect.
  - Set and clear on the same bit in the same cycle: set wins.
  - Bits above N_IRQ read 0 and ignore writes.
  - MASK is read/write; bits at and above N_IRQ are forced to 0.
- IRQ FSM, with active = |(PENDING & MASK):
  - IDLE: interrupt=0. Go to ASSERT when active.
  - ASSERT: interrupt=1, held until interrupt_ack. On ack go to SERVICE; interrupt drops the next cycle.
  - SERVICE: interrupt=0. Go to IDLE on any write to IRQ_BASE+0.
  - From IDLE, a still-active request re-asserts one cycle later. This handles new edges that arrive during service.
  - interrupt_ack outside ASSERT is ignored.
  - If active falls during ASSERT (mask cleared), interrupt stays high until ack; after that the normal SERVICE exit applies.
- Reset mid-operation: applies on the next edge from any state. No pulse may extend past reset.

Optional Feature:
- Macro: PBLAZE_IO_READBACK_EN.
- Defined: reads at OUT_BASE+i (i<N_OUT) return out_data channel i through the same registered mux, and the IN range takes priority on overlap. in_rd_pulse is not generated for readback addresses.
- Not defined: OUT addresses read 0x00 unless they fall in the IN range, and no readback mux is synthesised.

Test Plan:
- Reset: assert reset with irq_src=4'b0011 held high -> all outputs 0 and PENDING=0; release reset -> PENDING stays 0 and interrupt stays 0.
- Output write: write_strobe, port_id=0x02, out_port=0xA5 -> out_data ch2=0xA5 on the next edge; out_wr_pulse=4'b0100 for exactly 1 cycle.
- OUTPUTK: k_write_strobe, port_id=0x31, out_port=0x3C -> ch1=0x3C. With N_OUT=4, k_write_strobe to port_id=0x07 -> no change and no pulse.
- Input read: in_data ch3=0x5A, port_id=0x13 for 2 cycles, read_strobe in cycle 2 -> in_port=0x5A from cycle 2; in_rd_pulse[3] pulses once. port_id=0x40 -> in_port=0x00.
- Interrupt flow:
  - MASK=0x01, then pulse irq_src[0] -> PENDING=0x01; interrupt rises 1 cycle later.
  - Hold interrupt_ack low 5 cycles -> interrupt stays 1.
  - ack -> interrupt 0.
  - Write 0x01 to 0xF0 -> PENDING=0x00; FSM returns to IDLE with no re-assert.
- Collision and re-assert: rising edge on irq_src[1] in the same cycle as a W1C of bit 1, with MASK=0x02 -> PENDING[1]=1; interrupt re-asserts after the SERVICE exit.
